ef_smsdac_mse_chain: RTL and testbench

//  Parametrised fully-segmented mismatch-shaping encoder: NBITS chained switching stages (LSB first), on-chip LFSR dither.

---
 rtl/ef_smsdac_pkg.sv | 23 ++
 rtl/ef_smsdac_mse_sbx.sv | 52 +++++
 rtl/ef_smsdac_mse_chain.sv | 107 ++++++++++
 tb/tb_ef_smsdac_mse_chain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ef_smsdac_pkg.sv
// Shared constants for the segmented mismatch-shaping encoder.
// This file holds the dither LFSR taps, the default seed and the per-stage state record.
package ef_smsdac_pkg;

   localparam int          MAX_NBITS    = 16;
   localparam int          LFSR_W_DEF   = 16;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Per-stage shaping state.
   // q selects which polarity the next odd residue takes; q0 remembers the last toggle phase.
   typedef struct packed {
      logic q;
      logic q0;
   } stage_state_t;

   // One Fibonacci step for x^16+x^14+x^13+x^11+1.
   // Feedback is taken from bits 15,13,12,10 and shifted in at the LSB.
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ef_smsdac_mse_sbx.sv
// One switching stage of the mismatch-shaping chain.
// It splits a+c into a carry and a 3-level element value, and holds its own shaping state.
module ef_smsdac_mse_sbx
   import ef_smsdac_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic a,
   input  logic c,
   input  logic r,
   input  logic upd,
   input  logic shape_en,
   input  logic clr,
   output logic y0,
   output logic y1,
   output logic carry
);

   stage_state_t st_q;
   stage_state_t st_d;
   logic         odd;
   logic         q_eff;

   // An odd residue is sent to the element.
   // Its polarity comes from q, and the carry absorbs the remaining part.
   always_comb begin
      odd   = a ^ c;
      q_eff = shape_en & st_q.q;
      carry = odd ? q_eff : a;
      y1    = odd & ~q_eff;
      y0    = ~odd | ~q_eff;
   end

   always_comb begin
      st_d = st_q;
      if (clr) begin
         st_d = '0;
      end else if (upd && shape_en && odd) begin
         st_d.q0 = ~st_q.q0;
         st_d.q  = st_q.q ? r : ~st_q.q0;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         st_q <= '0;
      end else begin
         st_q <= st_d;
      end
   end

endmodule

// File: rtl/ef_smsdac_mse_chain.sv
// Fully-segmented mismatch-shaping encoder.
// It chains NBITS stages LSB first, uses LFSR dither, and registers the element drives.
module ef_smsdac_mse_chain
   import ef_smsdac_pkg::*;
#(
   parameter int                NBITS  = 4,
   parameter int                LFSR_W = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
)
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             in_valid,
   input  logic [NBITS-1:0] x,
   input  logic             x_cin,
   input  logic             shape_en,
   input  logic             dither_en,
   input  logic             clr,
   output logic             out_valid,
   output logic [NBITS-1:0] y0,
   output logic [NBITS-1:0] y1,
   output logic             y_msb
);

   localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

   logic [NBITS:0]    carry;
   logic [NBITS-1:0]  y0_c;
   logic [NBITS-1:0]  y1_c;
   logic [NBITS-1:0]  r_vec;
   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [NBITS-1:0]  y0_q;
   logic [NBITS-1:0]  y0_d;
   logic [NBITS-1:0]  y1_q;
   logic [NBITS-1:0]  y1_d;
   logic              y_msb_q;
   logic              y_msb_d;
   logic              out_valid_q;
   logic              out_valid_d;

   assign carry[0] = x_cin;
   assign r_vec    = dither_en ? lfsr_q[NBITS-1:0] : '0;

   // The carry ripples through every stage within one cycle.
   // The final carry becomes the MSB element.
   for (genvar i = 0; i < NBITS; i++) begin : g_stage
      ef_smsdac_mse_sbx u_sbx (
         .clk      (clk),
         .rst_b    (rst_b),
         .a        (x[i]),
         .c        (carry[i]),
         .r        (r_vec[i]),
         .upd      (in_valid),
         .shape_en (shape_en),
         .clr      (clr),
         .y0       (y0_c[i]),
         .y1       (y1_c[i]),
         .carry    (carry[i+1])
      );
   end

   always_comb begin
      lfsr_d = lfsr_q;
      if (clr) begin
         lfsr_d = SEED;
      end else if (in_valid && shape_en && dither_en) begin
         lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
      end
   end

   // Outputs hold their last sample between valid inputs.
   // out_valid marks only the cycle that follows an accepted sample.
   always_comb begin
      y0_d        = y0_q;
      y1_d        = y1_q;
      y_msb_d     = y_msb_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         y0_d    = y0_c;
         y1_d    = y1_c;
         y_msb_d = carry[NBITS];
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         lfsr_q      <= SEED;
         y0_q        <= '1;
         y1_q        <= '0;
         y_msb_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_d;
         y0_q        <= y0_d;
         y1_q        <= y1_d;
         y_msb_q     <= y_msb_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign y0        = y0_q;
   assign y1        = y1_q;
   assign y_msb     = y_msb_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ef_smsdac_mse_chain.sv
// Scoreboard bench for ef_smsdac_mse_chain (NBITS=4).
// An independent arithmetic model predicts every encoded sample.
module tb_ef_smsdac_mse_chain;

   localparam int NBITS = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct {
      logic [NBITS-1:0] y0;
      logic [NBITS-1:0] y1;
      logic             msb;
      int               value;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_b = 1'b0;
   logic             in_valid = 1'b0;
   logic [NBITS-1:0] x = '0;
   logic             x_cin = 1'b0;
   logic             shape_en = 1'b0;
   logic             dither_en = 1'b0;
   logic             clr = 1'b0;
   logic             out_valid;
   logic [NBITS-1:0] y0;
   logic [NBITS-1:0] y1;
   logic             y_msb;

   exp_t             sb[$];
   logic             mq[NBITS];
   logic             mq0[NBITS];
   logic [15:0]      mlfsr;
   logic [NBITS-1:0] last_y0;
   logic [NBITS-1:0] last_y1;
   logic             last_msb;
   int               checks = 0;
   int               errors = 0;

   ef_smsdac_mse_chain #(.NBITS(NBITS)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_valid  (in_valid),
      .x         (x),
      .x_cin     (x_cin),
      .shape_en  (shape_en),
      .dither_en (dither_en),
      .clr       (clr),
      .out_valid (out_valid),
      .y0        (y0),
      .y1        (y1),
      .y_msb     (y_msb)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < NBITS; i++) begin
         mq[i]  = 1'b0;
         mq0[i] = 1'b0;
      end
      mlfsr = SEED;
   endtask

   // Each stage splits s=a+c into 2*carry+v.
   // v is nonzero only when s==1, and its sign is chosen by the stage state.
   task automatic modelEncode(input logic [NBITS-1:0] xv, input logic cv, input logic sh,
                              input logic di, input logic cl, output exp_t e);
      logic c;
      logic nq;
      int   v;
      c       = cv;
      e.y0    = '0;
      e.y1    = '0;
      e.value = int'(xv) + int'(cv);
      for (int i = 0; i < NBITS; i++) begin
         if (int'(xv[i]) + int'(c) == 1) begin
            if (sh && mq[i]) begin
               v = -1;
               c = 1'b1;
            end else begin
               v = 1;
               c = 1'b0;
            end
            if (sh) begin
               nq     = mq[i] ? (di & mlfsr[i]) : ~mq0[i];
               mq0[i] = ~mq0[i];
               mq[i]  = nq;
            end
         end else begin
            v = 0;
            c = xv[i];
         end
         e.y0[i] = (v >= 0);
         e.y1[i] = (v == 1);
      end
      e.msb = c;
      if (sh && di) mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
      if (cl) modelClear();
   endtask

   function automatic int dutValue();
      int s;
      s = int'(y_msb) << NBITS;
      for (int i = 0; i < NBITS; i++) s += (int'(y0[i]) + int'(y1[i]) - 1) * (1 << i);
      return s;
   endfunction

   // Drives one cycle, steps the model and scores the registered result.
   task automatic applyStimulus(input logic v, input logic [NBITS-1:0] xv, input logic cv,
                                input logic sh, input logic di, input logic cl);
      exp_t e;
      in_valid  = v;
      x         = xv;
      x_cin     = cv;
      shape_en  = sh;
      dither_en = di;
      clr       = cl;
      if (v) begin
         modelEncode(xv, cv, sh, di, cl, e);
         sb.push_back(e);
      end else if (cl) begin
         modelClear();
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("out_valid", 32'(out_valid), 32'(v));
      if (out_valid) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            checkOutput("y0", 32'(y0), 32'(e.y0));
            checkOutput("y1", 32'(y1), 32'(e.y1));
            checkOutput("y_msb", 32'(y_msb), 32'(e.msb));
            checkOutput("invariant", 32'(dutValue()), 32'(e.value));
         end
      end else begin
         checkOutput("hold_y0", 32'(y0), 32'(last_y0));
         checkOutput("hold_y1", 32'(y1), 32'(last_y1));
         checkOutput("hold_msb", 32'(y_msb), 32'(last_msb));
      end
      last_y0  = y0;
      last_y1  = y1;
      last_msb = y_msb;
   endtask

   // Reset is asserted away from any clock edge.
   // Outputs must return to their reset values at once.
   task automatic applyReset();
      #2;
      rst_b = 1'b0;
      #1;
      checkOutput("rst_y0", 32'(y0), 32'hF);
      checkOutput("rst_y1", 32'(y1), 32'h0);
      checkOutput("rst_msb", 32'(y_msb), 32'h0);
      checkOutput("rst_valid", 32'(out_valid), 32'h0);
      in_valid = 1'b0;
      clr      = 1'b0;
      modelClear();
      sb.delete();
      last_y0  = '1;
      last_y1  = '0;
      last_msb = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      applyReset();

      applyStimulus(1, 4'hF, 1, 1, 0, 0);
      checkOutput("t2_y0", 32'(y0), 32'hF);
      checkOutput("t2_y1", 32'(y1), 32'h0);
      checkOutput("t2_msb", 32'(y_msb), 32'h1);

      applyStimulus(1, 4'h1, 0, 1, 0, 0);
      checkOutput("t3a_y1", 32'(y1), 32'b0001);
      checkOutput("t3a_y0", 32'(y0), 32'b1111);
      applyStimulus(1, 4'h1, 0, 1, 0, 0);
      checkOutput("t3b_y1", 32'(y1), 32'b0010);
      checkOutput("t3b_y0", 32'(y0), 32'b1110);
      applyStimulus(1, 4'h1, 0, 1, 0, 0);
      checkOutput("t3c_y1", 32'(y1), 32'b0001);
      checkOutput("t3c_y0", 32'(y0), 32'b1111);

      applyStimulus(1, 4'h1, 0, 1, 0, 1);
      checkOutput("t6_old_y1", 32'(y1), 32'b0100);
      checkOutput("t6_old_y0", 32'(y0), 32'b1100);
      applyStimulus(1, 4'h1, 0, 1, 0, 0);
      checkOutput("t6_new_y1", 32'(y1), 32'b0001);
      checkOutput("t6_new_y0", 32'(y0), 32'b1111);

      applyStimulus(1, 4'h3, 0, 1, 1, 0);
      applyStimulus(0, 4'h7, 1, 1, 1, 0);
      applyStimulus(0, 4'h9, 0, 1, 1, 0);
      applyStimulus(1, 4'h6, 1, 1, 1, 0);

      for (int i = 0; i < 8; i++) applyStimulus(1, NBITS'($urandom), 1'($urandom), 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 4'h5, 0, 0, 1, 0);
         checkOutput("t4_y1", 32'(y1), 32'b0101);
         checkOutput("t4_y0", 32'(y0), 32'hF);
      end
      for (int i = 0; i < 8; i++) applyStimulus(1, NBITS'($urandom), 1'($urandom), 1, 1, 0);

      in_valid = 1'b1;
      x        = 4'hA;
      applyReset();
      applyStimulus(1, 4'h1, 0, 1, 1, 0);
      checkOutput("t1_first_y1", 32'(y1), 32'b0001);

      for (int i = 0; i < 10000; i++) begin
         applyStimulus(($urandom_range(0, 9) < 8), NBITS'($urandom), 1'($urandom),
                       ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 99) < 2));
      end

      applyStimulus(0, 4'h0, 0, 1, 1, 0);
      checkOutput("sb_leftover", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
